// File: rtl/mesi_line_sequencer.sv
// Sequencer wrapped around the combinational cache_Mesi next-state block.
// It owns a direct-mapped tag/state array and runs each trace command in turn:
// lookup, then an optional writeback, then an optional bus operation, then the
// state update. For snoops it also returns this cache's own snoop response.
module mesi_line_sequencer #(
  parameter int ADDR_W      = 32,
  parameter int OFFSET_BITS = 6,
  parameter int INDEX_BITS  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  output logic              done,
  output logic              cmd_err,
  output logic              bus_req,
  output logic [2:0]        bus_op,
  output logic [ADDR_W-1:0] bus_addr,
  input  logic              bus_ack,
  input  logic [1:0]        bus_snoop_result,
  output logic [1:0]        put_snoop_result,
  output logic [1:0]        mesi_present,
  output logic [3:0]        mesi_command,
  output logic [1:0]        mesi_snoop,
  input  logic [1:0]        mesi_result
);
  localparam int TAG_W = ADDR_W - OFFSET_BITS - INDEX_BITS;
  localparam int LINES = 1 << INDEX_BITS;
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((1 << OFFSET_BITS) - 1);

  // line states as cache_Mesi encodes them
  localparam logic [1:0] ST_M = 2'b00, ST_E = 2'b01, ST_S = 2'b10, ST_I = 2'b11;
  localparam logic [2:0] BUS_NONE = 3'd0, BUS_READ = 3'd1, BUS_WRITE = 3'd2,
                         BUS_INV  = 3'd3, BUS_RFO  = 3'd4;
  localparam logic [1:0] SNP_NOHIT = 2'b00, SNP_HIT = 2'b01, SNP_HITM = 2'b10;
  localparam logic [3:0] OP_WR = 4'd1, OP_SRD = 4'd4, OP_SRFO = 4'd6,
                         OP_CLR = 4'd8, OP_PRT = 4'd9;

  typedef enum logic [2:0] {IDLE, LOOKUP, WB, BUS, UPDATE} seqState_t;

  typedef struct packed {
    logic [3:0]        op;
    logic [ADDR_W-1:0] addr;
  } cmdReq_t;

  seqState_t             state;
  cmdReq_t               cur;
  logic [TAG_W-1:0]      tagArr [LINES];
  logic [1:0]            stArr  [LINES];
  logic                  hitReg;
  logic [2:0]            pendOp;   // bus op that follows a victim writeback

  logic [INDEX_BITS-1:0] curIdx;
  logic [TAG_W-1:0]      curTag;
  logic [1:0]            lineSt;
  logic                  lineHit;
  logic [ADDR_W-1:0]     lineAddr;
  logic [ADDR_W-1:0]     victimAddr;
  logic                  isL1;
  logic                  isSnoop;
  logic [2:0]            missOp;

  assign curIdx     = cur.addr[OFFSET_BITS+INDEX_BITS-1:OFFSET_BITS];
  assign curTag     = cur.addr[ADDR_W-1:OFFSET_BITS+INDEX_BITS];
  assign lineSt     = stArr[curIdx];
  assign lineHit    = (tagArr[curIdx] == curTag) && (lineSt != ST_I);
  assign lineAddr   = cur.addr & ~OFF_MASK;
  assign victimAddr = {tagArr[curIdx], curIdx, {OFFSET_BITS{1'b0}}};
  assign isL1       = (cur.op <= 4'd2);
  assign isSnoop    = (cur.op >= 4'd3) && (cur.op <= OP_SRFO);
  assign missOp     = (cur.op == OP_WR) ? BUS_RFO : BUS_READ;

  // Command FSM, registered outputs and the line-state array
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      cmd_ready        <= 1'b1;
      done             <= 1'b0;
      cmd_err          <= 1'b0;
      bus_req          <= 1'b0;
      bus_op           <= BUS_NONE;
      bus_addr         <= '0;
      put_snoop_result <= SNP_NOHIT;
      mesi_present     <= ST_I;
      mesi_command     <= 4'd0;
      mesi_snoop       <= SNP_NOHIT;
      cur              <= '0;
      hitReg           <= 1'b0;
      pendOp           <= BUS_NONE;
      for (int i = 0; i < LINES; i++) stArr[INDEX_BITS'(i)] <= ST_I;
    end else begin
      done    <= 1'b0;
      cmd_err <= 1'b0;
      case (state)
        IDLE: if (cmd_valid) begin
          cur.op    <= cmd_op;
          cur.addr  <= cmd_addr;
          cmd_ready <= 1'b0;
          if (cmd_op <= OP_SRFO) begin
            state <= LOOKUP;
          end else begin
            // clear/print/undefined retire straight away; UPDATE writes nothing for them
            state   <= UPDATE;
            done    <= 1'b1;
            cmd_err <= !(cmd_op == OP_CLR || cmd_op == OP_PRT);
            if (cmd_op == OP_CLR)
              for (int i = 0; i < LINES; i++) stArr[INDEX_BITS'(i)] <= ST_I;
          end
        end
        LOOKUP: begin
          hitReg           <= lineHit;
          mesi_present     <= lineHit ? lineSt : ST_I;
          mesi_command     <= cur.op;
          mesi_snoop       <= SNP_NOHIT;
          put_snoop_result <= SNP_NOHIT;
          if (isSnoop) begin
            put_snoop_result <= !lineHit ? SNP_NOHIT : (lineSt == ST_M) ? SNP_HITM : SNP_HIT;
            // a dirty line must reach memory before another cache may read it
            if (lineHit && lineSt == ST_M && (cur.op == OP_SRD || cur.op == OP_SRFO)) begin
              state    <= WB;
              bus_req  <= 1'b1;
              bus_op   <= BUS_WRITE;
              bus_addr <= lineAddr;
            end else begin
              state <= UPDATE;
              done  <= 1'b1;
            end
          end else if (lineHit && (cur.op != OP_WR || lineSt != ST_S)) begin
            state <= UPDATE;
            done  <= 1'b1;
          end else if (lineHit) begin
            // write to a shared line: invalidate the other copies first
            state    <= BUS;
            bus_req  <= 1'b1;
            bus_op   <= BUS_INV;
            bus_addr <= lineAddr;
          end else begin
            pendOp  <= missOp;
            bus_req <= 1'b1;
            if (lineSt == ST_M) begin
              state    <= WB;
              bus_op   <= BUS_WRITE;
              bus_addr <= victimAddr;
            end else begin
              state    <= BUS;
              bus_op   <= missOp;
              bus_addr <= lineAddr;
            end
          end
        end
        WB: if (bus_ack) begin
          if (isL1) begin
            state    <= BUS;
            bus_op   <= pendOp;
            bus_addr <= lineAddr;
          end else begin
            state   <= UPDATE;
            done    <= 1'b1;
            bus_req <= 1'b0;
            bus_op  <= BUS_NONE;
          end
        end
        BUS: if (bus_ack) begin
          mesi_snoop <= bus_snoop_result;
          bus_req    <= 1'b0;
          bus_op     <= BUS_NONE;
          state      <= UPDATE;
          done       <= 1'b1;
        end
        UPDATE: begin
          // snoop misses leave the resident line alone
          if (isL1 || (isSnoop && hitReg)) stArr[curIdx] <= mesi_result;
          state     <= IDLE;
          cmd_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end

  // Tag store: tags are only meaningful while the line state is valid, so no reset
  always_ff @(posedge clk) begin
    if (!rst && state == UPDATE && isL1) tagArr[curIdx] <= curTag;
  end

endmodule

// File: tb/tb_mesi_line_sequencer.sv
// Directed bench for mesi_line_sequencer: a line-level cache model predicts
// bus traffic, mesi_* values, snoop responses and latency for each command.
module tb_mesi_line_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [3:0]  cmd_op = 4'd0;
  logic [31:0] cmd_addr = 32'd0;
  logic        done, cmd_err, bus_req;
  logic [2:0]  bus_op;
  logic [31:0] bus_addr;
  logic        bus_ack = 1'b0;
  logic [1:0]  bus_snoop_result = 2'b00;
  logic [1:0]  put_snoop_result, mesi_present, mesi_snoop, mesi_result;
  logic [3:0]  mesi_command;

  always #5 clk = ~clk;

  mesi_line_sequencer #(.ADDR_W(32), .OFFSET_BITS(6), .INDEX_BITS(4)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .done(done), .cmd_err(cmd_err),
    .bus_req(bus_req), .bus_op(bus_op), .bus_addr(bus_addr), .bus_ack(bus_ack),
    .bus_snoop_result(bus_snoop_result), .put_snoop_result(put_snoop_result),
    .mesi_present(mesi_present), .mesi_command(mesi_command),
    .mesi_snoop(mesi_snoop), .mesi_result(mesi_result)
  );

  // stand-in for cache_Mesi (M 0, E 1, S 2, I 3)
  function automatic logic [1:0] mesiNext(logic [1:0] p, logic [3:0] c, logic [1:0] s);
    case (c)
      4'd0, 4'd2: mesiNext = (p != 2'd3) ? p : ((s != 2'd0) ? 2'd2 : 2'd1);
      4'd1:       mesiNext = 2'd0;
      4'd3, 4'd6: mesiNext = 2'd3;
      4'd4:       mesiNext = (p == 2'd3) ? 2'd3 : 2'd2;
      default:    mesiNext = p;
    endcase
  endfunction
  assign mesi_result = mesiNext(mesi_present, mesi_command, mesi_snoop);

  int total = 0;
  int bad = 0;
  function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, got, exp);
    end
  endfunction

  typedef struct { logic [2:0] op; logic [31:0] addr; } busRec_t;
  busRec_t busLog[$];
  busRec_t expBus[$];

  logic [21:0] mTag [16];
  logic [1:0]  mSt  [16];

  int          ackDelay = 0;
  logic [1:0]  ackSnoop = 2'b00;
  int          ackCnt = 0;
  logic        active = 1'b0;
  int          nCyc = 0;
  int          expLat = 0;
  logic        expErr = 1'b0, expMesi = 1'b0, expSnp = 1'b0;
  logic [1:0]  expPres = 2'd3, expSnoopIn = 2'd0, expPut = 2'd0;
  logic [3:0]  expCmd = 4'd0;
  int          obsLat = 0;
  logic [1:0]  obsPres = 2'd0, obsSnoop = 2'd0, obsPut = 2'd0;

  // bus responder: ack after ackDelay waiting cycles, logging each operation
  always @(negedge clk) begin
    if (rst) begin
      bus_ack = 1'b0;
      ackCnt = 0;
    end else begin
      if (bus_ack) begin
        bus_ack = 1'b0;
        ackCnt = 0;
      end
      if (bus_req) begin
        if (ackCnt >= ackDelay) begin
          bus_ack = 1'b1;
          bus_snoop_result = ackSnoop;
          busLog.push_back('{bus_op, bus_addr});
        end else ackCnt++;
      end
    end
  end

  // compare process
  always @(negedge clk) begin
    if (active) begin
      nCyc++;
      if (done) begin
        obsLat = nCyc; obsPres = mesi_present; obsSnoop = mesi_snoop; obsPut = put_snoop_result;
        chk("latency", nCyc, expLat);
        chk("cmd_err", {31'd0, cmd_err}, {31'd0, expErr});
        if (expMesi) begin
          chk("mesi_present", {30'd0, mesi_present}, {30'd0, expPres});
          chk("mesi_command", {28'd0, mesi_command}, {28'd0, expCmd});
          chk("mesi_snoop", {30'd0, mesi_snoop}, {30'd0, expSnoopIn});
        end
        if (expSnp) chk("put_snoop", {30'd0, put_snoop_result}, {30'd0, expPut});
        chk("bus_count", busLog.size(), expBus.size());
        for (int i = 0; i < expBus.size() && i < busLog.size(); i++) begin
          chk("bus_op", {29'd0, busLog[i].op}, {29'd0, expBus[i].op});
          chk("bus_addr", busLog[i].addr, expBus[i].addr);
        end
        active = 1'b0;
      end else begin
        chk("busy_ready", {31'd0, cmd_ready}, 32'd0);
        if (nCyc > 300) begin
          chk("done_timeout", nCyc, expLat);
          active = 1'b0;
        end
      end
    end else if (!rst) begin
      chk("stray_done", {31'd0, done}, 32'd0);
    end
  end

  task automatic waitReady();
    int w = 0;
    @(negedge clk);
    while (!cmd_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!cmd_ready) chk("ready_timeout", {31'd0, cmd_ready}, 32'd1);
  endtask

  task automatic runCmd(input logic [3:0] op, input logic [31:0] addr, input int d, input logic [1:0] snp);
    int idx;
    logic [21:0] tg;
    logic [1:0] st, pres, snoopIn;
    logic [2:0] bop;
    logic hit;
    logic [31:0] line;
    idx = int'(addr[9:6]);
    tg = addr[31:10];
    line = addr & 32'hFFFF_FFC0;
    st = mSt[idx];
    hit = (st != 2'd3) && (mTag[idx] == tg);
    pres = hit ? st : 2'd3;
    snoopIn = 2'd0;
    expBus.delete();
    busLog.delete();
    expErr = 1'b0; expMesi = 1'b0; expSnp = 1'b0; expPut = 2'd0;
    ackDelay = d; ackSnoop = snp;
    if (op <= 4'd2) begin
      expMesi = 1'b1;
      if (!hit || (op == 4'd1 && st == 2'd2)) begin
        if (!hit && st == 2'd0) expBus.push_back('{3'd2, {mTag[idx], addr[9:6], 6'd0}});
        bop = (op != 4'd1) ? 3'd1 : (hit ? 3'd3 : 3'd4);
        expBus.push_back('{bop, line});
        snoopIn = snp;
      end
      mSt[idx] = mesiNext(pres, op, snoopIn);
      mTag[idx] = tg;
    end else if (op <= 4'd6) begin
      expMesi = 1'b1; expSnp = 1'b1;
      expPut = !hit ? 2'd0 : (st == 2'd0) ? 2'd2 : 2'd1;
      if (hit && st == 2'd0 && (op == 4'd4 || op == 4'd6)) expBus.push_back('{3'd2, line});
      if (hit) mSt[idx] = mesiNext(pres, op, 2'd0);
    end else begin
      if (op == 4'd8) for (int i = 0; i < 16; i++) mSt[i] = 2'd3;
      expErr = (op != 4'd8 && op != 4'd9);
    end
    expPres = pres; expSnoopIn = snoopIn; expCmd = op;
    expLat = (op <= 4'd6) ? 2 + expBus.size() * (d + 1) : 1;
    waitReady();
    cmd_op = op; cmd_addr = addr; cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    nCyc = 0;
    active = 1'b1;
    while (active) @(negedge clk);
  endtask

  function automatic logic [2:0] logOp(int i);
    logOp = (busLog.size() > i) ? busLog[i].op : 3'd7;
  endfunction
  function automatic logic [31:0] logAddr(int i);
    logAddr = (busLog.size() > i) ? busLog[i].addr : 32'hDEAD_BEEF;
  endfunction

  initial begin
    for (int i = 0; i < 16; i++) begin mSt[i] = 2'd3; mTag[i] = 22'd0; end
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, cmd_err}, 32'd0);
    chk("rst_busreq", {31'd0, bus_req}, 32'd0);
    chk("rst_busop", {29'd0, bus_op}, 32'd0);
    chk("rst_busaddr", bus_addr, 32'd0);
    chk("rst_put", {30'd0, put_snoop_result}, 32'd0);
    chk("rst_present", {30'd0, mesi_present}, 32'd3);
    chk("rst_command", {28'd0, mesi_command}, 32'd0);
    chk("rst_snoop", {30'd0, mesi_snoop}, 32'd0);
    rst = 1'b0;

    // read miss, other cache has it -> S
    runCmd(4'd0, 32'h0000_1040, 3, 2'b01);
    chk("tp1_busop", {29'd0, logOp(0)}, 32'd1);
    chk("tp1_lat", obsLat, 32'd6);
    chk("tp1_present", {30'd0, obsPres}, 32'd3);
    chk("tp1_snoop", {30'd0, obsSnoop}, 32'd1);
    chk("tp1_model_line", {30'd0, mSt[1]}, 32'd2);
    // write to S -> INVALIDATE, then M; second write is a pure hit
    runCmd(4'd1, 32'h0000_1040, 1, 2'b00);
    chk("tp2_busop", {29'd0, logOp(0)}, 32'd3);
    runCmd(4'd1, 32'h0000_1044, 0, 2'b00);
    chk("tp3_lat", obsLat, 32'd2);
    chk("tp3_nobus", busLog.size(), 32'd0);
    // conflict miss evicting the M line
    runCmd(4'd0, 32'h0001_1040, 0, 2'b00);
    chk("tp4_wb_addr", logAddr(0), 32'h0000_1040);
    chk("tp4_wb_op", {29'd0, logOp(0)}, 32'd2);
    chk("tp4_rd_addr", logAddr(1), 32'h0001_1040);
    // snoops against an M line, an absent tag, then the now-S line
    runCmd(4'd1, 32'h0000_2080, 0, 2'b00);
    runCmd(4'd4, 32'h0000_2080, 2, 2'b00);
    chk("tp5_put", {30'd0, obsPut}, 32'd2);
    chk("tp5_wb", {29'd0, logOp(0)}, 32'd2);
    runCmd(4'd4, 32'h0003_2080, 0, 2'b00);
    chk("tp6_put", {30'd0, obsPut}, 32'd0);
    runCmd(4'd4, 32'h0000_2080, 0, 2'b00);
    chk("tp6_still_s", {30'd0, obsPut}, 32'd1);
    // inst read hit on E, snoop_write, snoop_readRFO, refetch
    runCmd(4'd2, 32'h0001_1047, 0, 2'b00);
    runCmd(4'd5, 32'h0001_1040, 0, 2'b00);
    runCmd(4'd6, 32'h0001_1040, 0, 2'b00);
    runCmd(4'd3, 32'h0000_2080, 0, 2'b00);
    runCmd(4'd0, 32'h0001_1040, 1, 2'b10);
    // fills, clear, then every filled line must be gone
    runCmd(4'd0, 32'h0000_30C5, 0, 2'b00);
    chk("fill_align", logAddr(0), 32'h0000_30C0);
    runCmd(4'd1, 32'h0000_5100, 0, 2'b00);
    runCmd(4'd0, 32'h0000_A3F0, 2, 2'b01);
    runCmd(4'd8, 32'h0000_0000, 0, 2'b00);
    chk("clr_lat", obsLat, 32'd1);
    runCmd(4'd4, 32'h0000_30C5, 0, 2'b00);
    chk("clr_line3", {30'd0, obsPut}, 32'd0);
    runCmd(4'd4, 32'h0000_5100, 0, 2'b00);
    runCmd(4'd4, 32'h0000_A3F0, 0, 2'b00);
    runCmd(4'd4, 32'h0001_1040, 0, 2'b00);
    // undefined / print ops
    runCmd(4'd0, 32'h0000_7000, 0, 2'b00);
    runCmd(4'd7, 32'h0000_7000, 0, 2'b00);
    chk("err7_lat", obsLat, 32'd1);
    runCmd(4'd9, 32'h0000_7000, 0, 2'b00);
    runCmd(4'd12, 32'h0000_7000, 0, 2'b00);
    runCmd(4'd2, 32'h0000_7000, 0, 2'b00);
    chk("err_nochange", busLog.size(), 32'd0);

    // reset while waiting in BUS
    begin
      int w = 0;
      waitReady();
      ackDelay = 1000;
      cmd_op = 4'd0; cmd_addr = 32'h0000_6180; cmd_valid = 1'b1;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      while (!bus_req && w < 10) begin @(negedge clk); w++; end
      chk("midrst_busreq_seen", {31'd0, bus_req}, 32'd1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_busreq", {31'd0, bus_req}, 32'd0);
      chk("midrst_ready", {31'd0, cmd_ready}, 32'd1);
      chk("midrst_done", {31'd0, done}, 32'd0);
      for (int i = 0; i < 16; i++) mSt[i] = 2'd3;
    end
    runCmd(4'd4, 32'h0000_7000, 0, 2'b00);
    chk("midrst_line_gone", {30'd0, obsPut}, 32'd0);
    runCmd(4'd0, 32'h0000_7000, 0, 2'b00);
    chk("midrst_refetch", {29'd0, logOp(0)}, 32'd1);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
